// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: forward-select, hazard flags and load-use stall for decode.
// Outputs combinational from state and id_* in the same cycle; stall holds IF/ID and bubbles EX.
module hazard_scoreboard #(
  parameter int RA_W        = 2,
  parameter int STAGES      = 3,
  parameter int LOAD_READY  = 1,
  parameter int STALL_CNT_W = 16,
  parameter int FWD_W       = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [RA_W-1:0]        id_rs_a,
  input  logic                   id_use_a,
  input  logic [RA_W-1:0]        id_rs_b,
  input  logic                   id_use_b,
  input  logic                   id_wr_en,
  input  logic [RA_W-1:0]        id_rd,
  input  logic                   id_is_load,
  input  logic                   flush,
  output logic                   stall,
  output logic [FWD_W-1:0]       fwd_a,
  output logic [FWD_W-1:0]       fwd_b,
  output logic [1:0]             has_hazard,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] rd;
    logic            ld;
  } entry_t;

  typedef struct packed {
    logic             hit;
    logic             load_use;
    logic [FWD_W-1:0] fwd;
  } lookup_t;

  entry_t  sb [STAGES];
  lookup_t look_a;
  lookup_t look_b;

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  function automatic lookup_t lookup(input logic [RA_W-1:0] rs, input logic use_rs);
    lookup_t r;
    r = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (use_rs && sb[i].v && (sb[i].rd == rs)) begin
        r.hit      = 1'b1;
        r.load_use = sb[i].ld && (i < LOAD_READY);
        r.fwd      = FWD_W'(i + 1);
      end
    end
    return r;
  endfunction

  always_comb begin
    look_a     = lookup(id_rs_a, id_use_a);
    look_b     = lookup(id_rs_b, id_use_b);
    fwd_a      = look_a.fwd;
    fwd_b      = look_b.fwd;
    has_hazard = {look_a.hit, look_b.hit};
    stall      = id_valid && !flush && (look_a.load_use || look_b.load_use);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sb[i] <= '0;
    end else begin
      if (flush || stall) sb[0] <= '0;
      else                sb[0] <= '{v: id_valid && id_wr_en, rd: id_rd, ld: id_is_load};
      // Older entries keep advancing through a stall; flush also kills the EX instruction.
      for (int i = 1; i < STAGES; i++) begin
        if (i == 1 && flush) sb[i] <= '0;
        else                 sb[i] <= sb[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, ALU forwarding, load-use, priority, flush, counter saturation.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [1:0] id_rs_a;
  logic       id_use_a;
  logic [1:0] id_rs_b;
  logic       id_use_b;
  logic       id_wr_en;
  logic [1:0] id_rd;
  logic       id_is_load;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic [1:0] has_hazard;
  logic [1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  hazard_scoreboard #(
    .RA_W(2), .STAGES(3), .LOAD_READY(1), .STALL_CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs_a(id_rs_a), .id_use_a(id_use_a),
    .id_rs_b(id_rs_b), .id_use_b(id_use_b), .id_wr_en(id_wr_en),
    .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .has_hazard(has_hazard), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ra, input logic ua,
                       input logic [1:0] rb, input logic ub, input logic we,
                       input logic [1:0] rd, input logic ld, input logic fl);
    id_valid = v; id_rs_a = ra; id_use_a = ua; id_rs_b = rb; id_use_b = ub;
    id_wr_en = we; id_rd = rd; id_is_load = ld; flush = fl;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 2'd1, 1, 2'd1, 1, 1, 2'd1, 1, 0);
    repeat (3) step();
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL reset_fwd_a got=%0d exp=0", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin failures++; $display("FAIL reset_fwd_b got=%0d exp=0", fwd_b); end
    checks++; if (has_hazard !== 2'b00) begin failures++; $display("FAIL reset_hazard got=%b exp=00", has_hazard); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_fwd [4];
    logic [1:0] exp_hz  [4];
    exp_fwd[0] = 2'd1; exp_fwd[1] = 2'd2; exp_fwd[2] = 2'd3; exp_fwd[3] = 2'd0;
    exp_hz[0]  = 2'b10; exp_hz[1] = 2'b10; exp_hz[2] = 2'b10; exp_hz[3] = 2'b00;
    drive(1, 0, 0, 0, 0, 1, 2'd2, 0, 0);
    step();
    drive(1, 2'd2, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (fwd_a !== exp_fwd[k]) begin failures++; $display("FAIL alu_fwd_a[%0d] got=%0d exp=%0d", k, fwd_a, exp_fwd[k]); end
      checks++; if (has_hazard !== exp_hz[k]) begin failures++; $display("FAIL alu_hazard[%0d] got=%b exp=%b", k, has_hazard, exp_hz[k]); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall[%0d] got=%b exp=0", k, stall); end
      step();
    end
    idle(3);
  endtask

  task automatic test_load_use();
    drive(1, 0, 0, 0, 0, 1, 2'd1, 1, 0);
    step();
    drive(1, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall); end
    checks++; if (has_hazard !== 2'b01) begin failures++; $display("FAIL lu_hazard got=%b exp=01", has_hazard); end
    checks++; if (fwd_b !== 2'd1) begin failures++; $display("FAIL lu_fwd_b got=%0d exp=1", fwd_b); end
    step();
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lu_stall_next got=%b exp=0", stall); end
    checks++; if (fwd_b !== 2'd2) begin failures++; $display("FAIL lu_fwd_b_next got=%0d exp=2", fwd_b); end
    checks++; if (stall_cnt !== 2'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    idle(4);
  endtask

  task automatic test_youngest_wins();
    // Decode's own destination never matches its own sources.
    drive(1, 2'd3, 1, 2'd3, 1, 1, 2'd3, 0, 0);
    #1;
    checks++; if (has_hazard !== 2'b00) begin failures++; $display("FAIL self_hazard got=%b exp=00", has_hazard); end
    step();
    drive(1, 0, 0, 0, 0, 1, 2'd3, 0, 0);
    step();
    drive(1, 2'd3, 1, 2'd3, 1, 0, 0, 0, 0);
    #1;
    checks++; if (fwd_a !== 2'd1) begin failures++; $display("FAIL yw_fwd_a got=%0d exp=1", fwd_a); end
    checks++; if (fwd_b !== 2'd1) begin failures++; $display("FAIL yw_fwd_b got=%0d exp=1", fwd_b); end
    checks++; if (has_hazard !== 2'b11) begin failures++; $display("FAIL yw_hazard got=%b exp=11", has_hazard); end
    step();
    #1;
    checks++; if (fwd_a !== 2'd2) begin failures++; $display("FAIL yw_fwd_a_next got=%0d exp=2", fwd_a); end
    idle(4);
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 1, 2'd1, 1, 0);
    step();
    drive(1, 2'd1, 1, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall); end
    step();
    drive(1, 2'd1, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (fwd_a !== 2'd0) begin failures++; $display("FAIL fl_fwd_a got=%0d exp=0", fwd_a); end
    checks++; if (has_hazard !== 2'b00) begin failures++; $display("FAIL fl_hazard got=%b exp=00", has_hazard); end
    idle(4);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 0, 0, 1, 2'd1, 1, 0);
      step();
      drive(1, 2'd1, 1, 0, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (stall_cnt !== exp_cnt[k]) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", k, stall_cnt, exp_cnt[k]); end
      idle(3);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 0, 0, 0, 0, 1, 2'd2, 1, 0);
    step();
    drive(1, 2'd2, 1, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL mid_stall_pre got=%b exp=1", stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mid_stall_post got=%b exp=0", stall); end
    checks++; if (has_hazard !== 2'b00) begin failures++; $display("FAIL mid_hazard got=%b exp=00", has_hazard); end
    checks++; if (stall_cnt !== 2'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", stall_cnt); end
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest_wins();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
